core_sequencer: RTL and testbench

Multi-cycle sequencer for the 9-bit-instruction core. It owns the program counter and steps each instruction through fetch, execute and an optional data-memory wait. It gates register-file and data-memory writes with a single commit strobe, and uses the decoder's branch and done outputs to choose the next PC. It sits between the instruction ROM, the control decoder/register file and data memory, and reports run status to the testbench/top level.

---
 rtl/core_sequencer.sv | 132 +++++++++++++
 tb/tb_core_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/execute/memwait sequencer owning the PC and commit strobe
module core_sequencer #(
    parameter int PW      = 10,
    parameter int IW      = 9,
    parameter int TW      = 8,
    parameter int MEM_LAT = 2,
    parameter int CW      = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [IW-1:0] Instruction,
    input  logic          BranchUp,
    input  logic          BranchDown,
    input  logic [TW-1:0] PCTarget,
    input  logic          Ack,
    output logic [PW-1:0] PC,
    output logic          CommitEn,
    output logic          MemEn,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEMWAIT,
        S_DONE
    } state_t;

    localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [PW-1:0] PC_ONE = 1;
    localparam logic [WW-1:0] W_ONE  = 1;
    localparam logic [WW-1:0] W_INIT = WW'(MEM_LAT - 1);

    state_t        state;
    state_t        state_next;
    logic [WW-1:0] wait_cnt;
    logic          is_lw;
    logic          wait_done;
    logic [PW-1:0] pc_offset;
    logic          unused_ok;

    assign is_lw     = (Instruction[IW-1:IW-5] == 5'b00010);
    assign wait_done = (wait_cnt == '0);
    assign pc_offset = {{(PW-TW){1'b0}}, PCTarget};
    assign unused_ok = ^Instruction[IW-6:0];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (Start) state_next = S_FETCH;
            S_FETCH:   state_next = S_EXEC;
            S_EXEC: begin
                if (Ack)        state_next = S_DONE;
                else if (is_lw) state_next = S_MEMWAIT;
                else            state_next = S_FETCH;
            end
            S_MEMWAIT: if (wait_done) state_next = S_FETCH;
            S_DONE:    if (Start) state_next = S_FETCH;
            default:   state_next = S_IDLE;
        endcase
    end

    // Strobes depend only on state plus the decoder's view of the current instruction.
    always_comb begin
        CommitEn = 1'b0;
        MemEn    = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            S_FETCH: Busy = 1'b1;
            S_EXEC: begin
                Busy     = 1'b1;
                CommitEn = !Ack && !is_lw;
                MemEn    = !Ack && is_lw;
            end
            S_MEMWAIT: begin
                Busy     = 1'b1;
                MemEn    = 1'b1;
                CommitEn = wait_done;
            end
            S_DONE:  Done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            PC         <= '0;
            CycleCount <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        PC         <= '0;
                        CycleCount <= '0;
                    end
                end
                S_EXEC: begin
                    if (!Ack && is_lw) begin
                        wait_cnt <= W_INIT;
                    end else if (!Ack) begin
                        if (BranchDown)    PC <= PC + pc_offset;
                        else if (BranchUp) PC <= PC - pc_offset;
                        else               PC <= PC + PC_ONE;
                    end
                end
                S_MEMWAIT: begin
                    if (wait_done) PC <= PC + PC_ONE;
                    else           wait_cnt <= wait_cnt - W_ONE;
                end
                default: ;
            endcase
            if (Busy && (CycleCount != '1)) begin
                CycleCount <= CycleCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - table-driven and randomized self-checking bench for core_sequencer
module tb_core_sequencer;

    localparam int MEM_LAT = 2;
    localparam int PCMOD   = 1024;
    localparam int CCMAX   = 65535;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [8:0]  Instruction;
    logic        BranchUp;
    logic        BranchDown;
    logic [7:0]  PCTarget;
    logic        Ack;
    logic [9:0]  PC;
    logic        CommitEn;
    logic        MemEn;
    logic        Busy;
    logic        Done;
    logic [15:0] CycleCount;

    core_sequencer #(.PW(10), .IW(9), .TW(8), .MEM_LAT(MEM_LAT), .CW(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instruction(Instruction),
        .BranchUp(BranchUp), .BranchDown(BranchDown), .PCTarget(PCTarget), .Ack(Ack),
        .PC(PC), .CommitEn(CommitEn), .MemEn(MemEn), .Busy(Busy), .Done(Done),
        .CycleCount(CycleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int passed = 0;
    int total  = 0;
    int mpc    = 0;
    int mcc    = 0;

    typedef struct {
        logic [8:0] ins;
        logic       bd;
        logic       bu;
        logic [7:0] tgt;
        int         exp_pc;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else passed++;
    endtask

    // Entered just after the edge that lands in FETCH; leaves just after the edge that ends the instruction.
    task automatic do_instr(input logic [8:0] ins, input logic bd, input logic bu,
                            input logic [7:0] tgt, input logic ack, input int exp_pc);
        logic lw;
        lw = (ins[8:4] == 5'b00010) && !ack;
        @(negedge Clk);
        chk("fetch_busy", Busy, 1);
        chk("fetch_strobes", {CommitEn, MemEn}, 0);
        Instruction = ins; BranchDown = bd; BranchUp = bu; PCTarget = tgt; Ack = ack;
        @(posedge Clk); #1;
        @(negedge Clk);
        chk("exec_commit", CommitEn, (!ack && !lw));
        chk("exec_memen", MemEn, lw);
        @(posedge Clk); #1;
        if (lw) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                @(negedge Clk);
                chk("wait_memen", MemEn, 1);
                chk("wait_commit", CommitEn, (i == MEM_LAT - 1));
                @(posedge Clk); #1;
            end
        end
        Instruction = 9'h0; BranchDown = 0; BranchUp = 0; PCTarget = 0; Ack = 0;
        mcc = mcc + (lw ? 2 + MEM_LAT : 2);
        if (mcc > CCMAX) mcc = CCMAX;
        chk("pc", PC, exp_pc);
        chk("cycles", CycleCount, mcc);
        if (ack) chk("done", Done, 1);
        else     chk("busy", Busy, 1);
        mpc = exp_pc;
    endtask

    task automatic launch();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        mcc = 0;
        mpc = 0;
        chk("launch_busy", Busy, 1);
        chk("launch_pc", PC, 0);
        chk("launch_cycles", CycleCount, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{9'h0A5, 0, 0, 8'd0, 1};
        tbl[1]  = '{9'h131, 0, 0, 8'd7, 2};
        tbl[2]  = '{9'h0A5, 0, 0, 8'd0, 3};
        tbl[3]  = '{9'h0A5, 1, 0, 8'd5, 8};
        tbl[4]  = '{9'h0A5, 0, 1, 8'd2, 6};
        tbl[5]  = '{9'h0A5, 1, 1, 8'd1, 7};
        tbl[6]  = '{9'h023, 1, 0, 8'd9, 8};
        tbl[7]  = '{9'h0A5, 0, 1, 8'd9, 1023};
        tbl[8]  = '{9'h0A5, 0, 0, 8'd0, 0};
        tbl[9]  = '{9'h0A5, 0, 0, 8'd0, 1};
        tbl[10] = '{9'h0A5, 0, 1, 8'd4, 1021};
        tbl[11] = '{9'h0A5, 1, 0, 8'd3, 0};

        Reset = 1; Start = 0; Instruction = 0; BranchUp = 0; BranchDown = 0; PCTarget = 0; Ack = 0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_pc", PC, 0);
        chk("rst_cycles", CycleCount, 0);
        chk("rst_flags", {Busy, Done, CommitEn, MemEn}, 0);
        @(posedge Clk); #1;
        Reset = 0;
        @(posedge Clk); #1;
        chk("idle_busy", Busy, 0);

        // ALU op followed by halt
        launch();
        do_instr(9'h0A5, 0, 0, 8'd0, 0, 1);
        do_instr(9'h1FF, 0, 0, 8'd0, 1, 1);
        chk("halt_cycles4", CycleCount, 4);
        repeat (3) @(posedge Clk);
        #1;
        chk("done_hold", Done, 1);
        chk("done_pc_frozen", PC, 1);
        chk("done_cc_frozen", CycleCount, 4);

        launch();
        for (int i = 0; i < 12; i++) begin
            do_instr(tbl[i].ins, tbl[i].bd, tbl[i].bu, tbl[i].tgt, 0, tbl[i].exp_pc);
        end

        for (int i = 0; i < 40; i++) begin
            logic [8:0] ins;
            logic bd, bu;
            logic [7:0] tgt;
            int nxt;
            ins = 9'($urandom);
            bd  = 1'($urandom);
            bu  = 1'($urandom);
            tgt = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ins[8:4] = 5'b00010;
            else if (ins[8:4] == 5'b00010) ins[8] = 1'b1;
            if (ins[8:4] == 5'b00010) nxt = mpc + 1;
            else if (bd)              nxt = mpc + int'(tgt);
            else if (bu)              nxt = mpc - int'(tgt);
            else                      nxt = mpc + 1;
            nxt = ((nxt % PCMOD) + PCMOD) % PCMOD;
            do_instr(ins, bd, bu, tgt, 0, nxt);
        end
        do_instr(9'h1FF, 1, 1, 8'd3, 1, mpc);

        // Reset asserted during the first MEMWAIT cycle
        launch();
        Instruction = 9'h02A;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("memwait_memen", MemEn, 1);
        Reset = 1;
        #1;
        chk("async_pc", PC, 0);
        chk("async_cycles", CycleCount, 0);
        chk("async_flags", {MemEn, CommitEn, Busy}, 0);
        @(posedge Clk); #1;
        Reset = 0;
        Instruction = 0;
        @(posedge Clk); #1;
        chk("post_rst_idle", {Busy, Done}, 0);

        // Start held high through the whole run
        Start = 1;
        @(posedge Clk); #1;
        mcc = 0;
        mpc = 0;
        do_instr(9'h0A5, 0, 0, 8'd0, 0, 1);
        do_instr(9'h0A5, 0, 0, 8'd0, 0, 2);
        do_instr(9'h1FF, 0, 0, 8'd0, 1, 2);
        @(posedge Clk); #1;
        chk("relaunch_busy", Busy, 1);
        chk("relaunch_pc", PC, 0);
        chk("relaunch_cycles", CycleCount, 0);
        Start = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
